unary_hls_deadlock_detector: RTL and testbench
==============================================

# unary_hls_deadlock_detector

Persistence filter and report latch that consumes the per-instance `block` outputs of the `unary` HLS deadlock monitors. It qualifies a block condition only after it has held for a programmable number of consecutive cycles. It then latches a sticky deadlock flag, the index of the offending monitor, and a saturating event count for the host and simulation harness. It sits directly downstream of the monitor tree, one per kernel.

## Interface
- `NUM_MONITORS`, default 4: number of monitor `block` inputs (1..32).
- `THRESHOLD`, default 1024: consecutive blocked cycles required to declare deadlock (2..2^CNT_WIDTH-1).
- `CNT_WIDTH`, default 16: width of the persistence counter.
- `ID_WIDTH`, default 5: width of `deadlock_id`; must satisfy 2^ID_WIDTH >= NUM_MONITORS.

Ports:
- `clock` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `block_in` in NUM_MONITORS: `block` outputs of the monitors, bit i = monitor i.
- `enable` in 1: arms detection; level-sensitive.
- `clear` in 1: single-cycle pulse; clears the report and counter.
- `deadlock` out 1: sticky deadlock flag.
- `deadlock_pulse` out 1: one-cycle strobe on entry to REPORTED.
- `deadlock_id` out ID_WIDTH: lowest-index monitor blocked at detection.
- `block_cycles` out CNT_WIDTH: current persistence count.
- `event_count` out 8: number of deadlocks reported, saturating.

## Operation
- `block_in` is registered once into `block_q`; `any_blk` = OR of `block_q`. No other input is pipelined.
- FSM states: IDLE, COUNT, REPORTED.
- IDLE
  - `cnt` = 0.
  - If `enable` & `any_blk` & !`clear`: go to COUNT with `cnt` = 1.
- COUNT
  - If `clear` or !`enable` or !`any_blk`: go to IDLE with `cnt` = 0. A single-cycle drop of `any_blk` restarts qualification.
  - Else if `cnt` == THRESHOLD-1: go to REPORTED and assert `deadlock_pulse` for one cycle. Latch `deadlock_id` = index of the lowest set bit of `block_q` in that cycle. Increment `event_count`, saturating at 255. `cnt` holds.
  - Else `cnt` += 1.
- REPORTED
  - `deadlock` = 1, independent of `enable` and `block_in`.
  - `clear` returns the FSM to IDLE with `cnt` = 0 and `deadlock` = 0. `deadlock_id` holds its last value.
- Simultaneous events:
  - `clear` and the detection condition in the same cycle: `clear` wins; no pulse, no count increment.
  - `clear` in IDLE is a no-op.
- `event_count` is cleared only by reset, never by `clear`.
- `block_cycles` = `cnt`. It never exceeds THRESHOLD-1, so no wrap is possible.
- Reset values (asynchronous on `reset_n` low): `block_q` = 0, state = IDLE, `deadlock` = 0, `deadlock_pulse` = 0, `deadlock_id` = 0, `block_cycles` = 0, `event_count` = 0.
- Reset asserted mid-COUNT or in REPORTED returns everything to the reset values immediately, without waiting for a clock edge. Operation resumes on the first edge after `reset_n` rises.

## Timing
- Let E0 be the first rising edge at which `block_in` is sampled non-zero, with `enable` = 1.
  - `block_cycles` = 1 after edge E0+1.
  - `deadlock` and `deadlock_pulse` rise after edge E0+THRESHOLD, provided `block_in` is non-zero at every edge E0..E0+THRESHOLD-1.
  - Total latency from the input to the flag is therefore THRESHOLD cycles.
- `deadlock_pulse` is high for exactly one cycle per report.
- `deadlock_id`, `event_count` and `deadlock` update on the same edge as `deadlock_pulse`.
- `clear` sampled at edge Ec: `deadlock` = 0 and `block_cycles` = 0 after Ec.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- THRESHOLD=4, `enable`=1, `block_in`=4'b0100 from edge 0 onward:
  - `deadlock_pulse` high only after edge 4.
  - `deadlock_id`=2, `event_count`=1.
  - `deadlock` stays 1 after `block_in` returns to 0.
- THRESHOLD=4, `block_in`=4'b0001 at edges 0-2, 0 at edge 3, then 4'b0001 again: `block_cycles` returns to 0; `deadlock` rises only after edge 8.
- Detection cycle with `block_in`=4'b1010 throughout: `deadlock_id`=1.
- `clear` pulsed in the same cycle as the detection condition: no pulse, `event_count` unchanged, state IDLE.
- `enable`=0 with `block_in`=4'b1111 for 100 cycles: `deadlock`=0 and `block_cycles`=0 throughout.
- 260 detect/clear cycles: `event_count` saturates at 255.
- Mid-COUNT: `reset_n` low asynchronously between edges drives all outputs to 0 immediately, before the next edge.

Source files
------------

// File: rtl/unary_hls_deadlock_detector.sv
// rtl/unary_hls_deadlock_detector.sv - persistence filter and sticky deadlock report for unary HLS monitors
module unary_hls_deadlock_detector #(
    parameter int NUM_MONITORS = 4,
    parameter int THRESHOLD    = 1024,
    parameter int CNT_WIDTH    = 16,
    parameter int ID_WIDTH     = 5
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_MONITORS-1:0] block_in,
    input  logic                    enable,
    input  logic                    clear,
    output logic                    deadlock,
    output logic                    deadlock_pulse,
    output logic [ID_WIDTH-1:0]     deadlock_id,
    output logic [CNT_WIDTH-1:0]    block_cycles,
    output logic [7:0]              event_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        REPORTED = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(THRESHOLD - 1);

    state_t                  state_q, state_d;
    logic [NUM_MONITORS-1:0] block_q, block_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    deadlock_q, deadlock_d;
    logic                    pulse_q, pulse_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [7:0]              events_q, events_d;
    logic                    any_blk;
    logic [ID_WIDTH-1:0]     low_id;

    assign any_blk = |block_q;

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        low_id = '0;
        for (int i = NUM_MONITORS - 1; i >= 0; i--) begin
            if (block_q[i]) begin
                low_id = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        block_d    = block_in;
        cnt_d      = cnt_q;
        deadlock_d = deadlock_q;
        pulse_d    = 1'b0;
        id_d       = id_q;
        events_d   = events_q;
        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                deadlock_d = 1'b0;
                if (enable && any_blk && !clear) begin
                    state_d = COUNT;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
            COUNT: begin
                if (clear || !enable || !any_blk) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = REPORTED;
                    deadlock_d = 1'b1;
                    pulse_d    = 1'b1;
                    id_d       = low_id;
                    if (events_q != 8'hFF) begin
                        events_d = events_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            REPORTED: begin
                deadlock_d = 1'b1;
                if (clear) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    deadlock_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                deadlock_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            block_q    <= '0;
            cnt_q      <= '0;
            deadlock_q <= 1'b0;
            pulse_q    <= 1'b0;
            id_q       <= '0;
            events_q   <= '0;
        end else begin
            state_q    <= state_d;
            block_q    <= block_d;
            cnt_q      <= cnt_d;
            deadlock_q <= deadlock_d;
            pulse_q    <= pulse_d;
            id_q       <= id_d;
            events_q   <= events_d;
        end
    end

    assign deadlock       = deadlock_q;
    assign deadlock_pulse = pulse_q;
    assign deadlock_id    = id_q;
    assign block_cycles   = cnt_q;
    assign event_count    = events_q;

endmodule

// File: tb/tb_unary_hls_deadlock_detector.sv
// tb/tb_unary_hls_deadlock_detector.sv - self-checking bench for unary_hls_deadlock_detector
module tb_unary_hls_deadlock_detector;

    logic        clock;
    logic        reset_n;
    logic [3:0]  block_in;
    logic        enable;
    logic        clear;
    logic        deadlock;
    logic        deadlock_pulse;
    logic [4:0]  deadlock_id;
    logic [15:0] block_cycles;
    logic [7:0]  event_count;

    int checks = 0;
    int errors = 0;

    unary_hls_deadlock_detector #(
        .NUM_MONITORS(4),
        .THRESHOLD   (4),
        .CNT_WIDTH   (16),
        .ID_WIDTH    (5)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .block_in      (block_in),
        .enable        (enable),
        .clear         (clear),
        .deadlock      (deadlock),
        .deadlock_pulse(deadlock_pulse),
        .deadlock_id   (deadlock_id),
        .block_cycles  (block_cycles),
        .event_count   (event_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  blk;
        logic        en;
        logic        clr;
        logic        dl;
        logic        p;
        logic [4:0]  id;
        logic [15:0] cyc;
        logic [7:0]  ev;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] blk, input logic en, input logic clr, input logic dl,
                       input logic p, input logic [4:0] id, input logic [15:0] cyc, input logic [7:0] ev);
        vec_t v;
        v.blk = blk; v.en = en; v.clr = clr; v.dl = dl; v.p = p; v.id = id; v.cyc = cyc; v.ev = ev;
        vecs.push_back(v);
    endtask

    // Drive one record, push its expectation, clock once and compare against the popped entry.
    task automatic step(input vec_t v);
        vec_t e;
        block_in = v.blk;
        enable   = v.en;
        clear    = v.clr;
        sb.push_back(v);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty");
        end else begin
            e = sb.pop_front();
            chk("deadlock", 32'(deadlock), 32'(e.dl));
            chk("deadlock_pulse", 32'(deadlock_pulse), 32'(e.p));
            chk("deadlock_id", 32'(deadlock_id), 32'(e.id));
            chk("block_cycles", 32'(block_cycles), 32'(e.cyc));
            chk("event_count", 32'(event_count), 32'(e.ev));
        end
    endtask

    task automatic do_step(input logic [3:0] blk, input logic en, input logic clr, input logic dl,
                           input logic p, input logic [4:0] id, input logic [15:0] cyc, input logic [7:0] ev);
        vec_t v;
        v.blk = blk; v.en = en; v.clr = clr; v.dl = dl; v.p = p; v.id = id; v.cyc = cyc; v.ev = ev;
        step(v);
    endtask

    initial begin
        int exp_ev;
        reset_n  = 1'b0;
        block_in = 4'b0;
        enable   = 1'b0;
        clear    = 1'b0;

        // blk en clr | dl p id cyc ev  (row n: inputs sampled at edge n, outputs after it)
        add(4'b0100, 1, 0, 0, 0, 0, 0, 0);
        add(4'b0100, 1, 0, 0, 0, 0, 1, 0);
        add(4'b0100, 1, 0, 0, 0, 0, 2, 0);
        add(4'b0100, 1, 0, 0, 0, 0, 3, 0);
        add(4'b0000, 1, 0, 1, 1, 2, 3, 1);
        add(4'b0000, 1, 0, 1, 0, 2, 3, 1);
        add(4'b0000, 0, 0, 1, 0, 2, 3, 1);
        add(4'b0000, 1, 1, 0, 0, 2, 0, 1);
        add(4'b0000, 1, 0, 0, 0, 2, 0, 1);
        add(4'b0001, 1, 0, 0, 0, 2, 0, 1);
        add(4'b0001, 1, 0, 0, 0, 2, 1, 1);
        add(4'b0001, 1, 0, 0, 0, 2, 2, 1);
        add(4'b0000, 1, 0, 0, 0, 2, 3, 1);
        add(4'b0001, 1, 0, 0, 0, 2, 0, 1);
        add(4'b0001, 1, 0, 0, 0, 2, 1, 1);
        add(4'b0001, 1, 0, 0, 0, 2, 2, 1);
        add(4'b0001, 1, 0, 0, 0, 2, 3, 1);
        add(4'b0001, 1, 0, 1, 1, 0, 3, 2);
        add(4'b0001, 1, 0, 1, 0, 0, 3, 2);
        add(4'b0000, 1, 1, 0, 0, 0, 0, 2);
        add(4'b0000, 1, 0, 0, 0, 0, 0, 2);
        add(4'b1010, 1, 0, 0, 0, 0, 0, 2);
        add(4'b1010, 1, 0, 0, 0, 0, 1, 2);
        add(4'b1010, 1, 0, 0, 0, 0, 2, 2);
        add(4'b1010, 1, 0, 0, 0, 0, 3, 2);
        add(4'b1010, 1, 0, 1, 1, 1, 3, 3);
        add(4'b0000, 1, 1, 0, 0, 1, 0, 3);
        add(4'b0000, 1, 0, 0, 0, 1, 0, 3);
        add(4'b0001, 1, 0, 0, 0, 1, 0, 3);
        add(4'b0001, 1, 0, 0, 0, 1, 1, 3);
        add(4'b0001, 1, 0, 0, 0, 1, 2, 3);
        add(4'b0001, 1, 0, 0, 0, 1, 3, 3);
        add(4'b0000, 1, 1, 0, 0, 1, 0, 3);
        add(4'b0000, 1, 1, 0, 0, 1, 0, 3);
        add(4'b0000, 1, 0, 0, 0, 1, 0, 3);

        #12;
        chk("reset_deadlock", 32'(deadlock), 32'd0);
        chk("reset_pulse", 32'(deadlock_pulse), 32'd0);
        chk("reset_id", 32'(deadlock_id), 32'd0);
        chk("reset_cycles", 32'(block_cycles), 32'd0);
        chk("reset_events", 32'(event_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        for (int i = 0; i < 100; i++) begin
            do_step(4'b1111, 0, 0, 0, 0, 1, 0, 3);
        end
        do_step(4'b0000, 0, 0, 0, 0, 1, 0, 3);
        do_step(4'b0000, 1, 0, 0, 0, 1, 0, 3);

        exp_ev = 3;
        for (int k = 0; k < 260; k++) begin
            do_step(4'b0001, 1, 0, 0, 0, (k == 0) ? 5'd1 : 5'd0, 0, 8'(exp_ev));
            do_step(4'b0001, 1, 0, 0, 0, (k == 0) ? 5'd1 : 5'd0, 1, 8'(exp_ev));
            do_step(4'b0001, 1, 0, 0, 0, (k == 0) ? 5'd1 : 5'd0, 2, 8'(exp_ev));
            do_step(4'b0001, 1, 0, 0, 0, (k == 0) ? 5'd1 : 5'd0, 3, 8'(exp_ev));
            if (exp_ev < 255) exp_ev++;
            do_step(4'b0000, 1, 0, 1, 1, 0, 3, 8'(exp_ev));
            do_step(4'b0000, 1, 1, 0, 0, 0, 0, 8'(exp_ev));
        end
        chk("event_saturated", 32'(event_count), 32'd255);

        do_step(4'b0001, 1, 0, 0, 0, 0, 0, 255);
        do_step(4'b0001, 1, 0, 0, 0, 0, 1, 255);
        do_step(4'b0001, 1, 0, 0, 0, 0, 2, 255);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_deadlock", 32'(deadlock), 32'd0);
        chk("async_pulse", 32'(deadlock_pulse), 32'd0);
        chk("async_id", 32'(deadlock_id), 32'd0);
        chk("async_cycles", 32'(block_cycles), 32'd0);
        chk("async_events", 32'(event_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        do_step(4'b0010, 1, 0, 0, 0, 0, 0, 0);
        do_step(4'b0010, 1, 0, 0, 0, 0, 1, 0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
